// File: rtl/pipe_ctrl_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU encodings, condition
// codes, control bundle and ID/EX payload types, and the condition evaluator.
package pipe_ctrl_pkg;

  localparam logic [5:0]  OPC_ADDI  = 6'b100100;
  localparam logic [5:0]  OPC_ADDS  = 6'b101010;
  localparam logic [5:0]  OPC_SUBS  = 6'b111010;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [5:0]  OPC_CBZ   = 6'b101101;
  localparam logic [5:0]  OPC_BCOND = 6'b010101;
  localparam logic [5:0]  OPC_MOVZ  = 6'b110100;
  localparam logic [5:0]  OPC_MOVK  = 6'b111100;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STURB = 11'b00111000000;
  localparam logic [10:0] OPC_LDURB = 11'b00111000010;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;

  localparam logic [3:0] XFER_BYTE  = 4'b0001;
  localparam logic [3:0] XFER_DWORD = 4'b1000;

  typedef struct packed {
    logic       reg2loc;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       move;
    logic       zork;
    logic       iorr;
    logic       bor8;
  } ctrl_t;

  localparam ctrl_t CTRL_ADDI  = 13'b0000010110000;
  localparam ctrl_t CTRL_ADDS  = 13'b1000010010000;
  localparam ctrl_t CTRL_SUBS  = 13'b1000011010000;
  localparam ctrl_t CTRL_STUR  = 13'b0101010100010;
  localparam ctrl_t CTRL_LDUR  = 13'b0011010110010;
  localparam ctrl_t CTRL_MOVZ  = 13'b0000010111000;
  localparam ctrl_t CTRL_MOVK  = 13'b0000010011100;
  localparam ctrl_t CTRL_STURB = 13'b0101010100011;
  localparam ctrl_t CTRL_LDURB = 13'b0011010110011;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADDI, OP_ADDS, OP_SUBS, OP_B, OP_CBZ, OP_BCOND,
    OP_MOVZ, OP_MOVK, OP_STUR, OP_LDUR, OP_STURB, OP_LDURB
  } op_e;

  // ID/EX status and control payload; the XLEN-wide immediate travels alongside
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       set_flags;
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [5:0] shamt;
    logic [3:0] xfer;
  } idex_t;

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, gt;
    logic r;
    {n, z, c, v} = nzcv;
    gt = !z && (n == v);
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_HS: r = c;
      COND_LO: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !(c && !z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = gt;
      COND_LE: r = !gt;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_decode_ctrl_idex_reg.sv
// ID/EX pipeline register with reset > flush > stall > bubble > load priority.
module idex_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            bubble,
  input  idex_t           d,
  input  logic [XLEN-1:0] d_imm,
  output idex_t           q,
  output logic [XLEN-1:0] q_imm
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q     <= '0;
      q_imm <= '0;
    end else if (!stall) begin
      if (bubble) begin
        q     <= '0;
        q_imm <= '0;
      end else begin
        q     <= d;
        q_imm <= d_imm;
      end
    end
  end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// ID-stage decoder: combinational register addresses and branch resolution,
// registered ID/EX control bundle, and the architectural NZCV flag register.
module pipe_decode_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned BYTE_OPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            zero_in,
  input  logic [3:0]      flags_in,
  output logic [4:0]      rn,
  output logic [4:0]      rm,
  output logic            br_taken,
  output logic            flag_stall,
  output logic [XLEN-1:0] br_offset,
  output logic            ex_valid,
  output logic            ex_illegal,
  output logic            ex_set_flags,
  output logic [12:0]     ex_ctrl,
  output logic [4:0]      ex_rd,
  output logic [5:0]      ex_shamt,
  output logic [3:0]      ex_xfer,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      flags
);

  op_e             op;
  idex_t           d;
  idex_t           q;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] imm_addi, imm_mem, imm_mov, off26, off19;

  assign imm_addi = {{(XLEN-12){1'b0}}, instruction[21:10]};
  assign imm_mem  = {{(XLEN-9){instruction[20]}}, instruction[20:12]};
  assign imm_mov  = {{(XLEN-16){1'b0}}, instruction[20:5]};
  assign off26    = {{(XLEN-26){instruction[25]}}, instruction[25:0]};
  assign off19    = {{(XLEN-19){instruction[23]}}, instruction[23:5]};

  // Opcode classification; 11-bit memory opcodes never alias a 6-bit one
  always_comb begin
    op = OP_ILL;
    if (instruction[31:21] == OPC_STUR)       op = OP_STUR;
    else if (instruction[31:21] == OPC_LDUR)  op = OP_LDUR;
    else if (instruction[31:21] == OPC_STURB) op = (BYTE_OPS != 0) ? OP_STURB : OP_ILL;
    else if (instruction[31:21] == OPC_LDURB) op = (BYTE_OPS != 0) ? OP_LDURB : OP_ILL;
    else begin
      case (instruction[31:26])
        OPC_ADDI:  op = OP_ADDI;
        OPC_ADDS:  op = OP_ADDS;
        OPC_SUBS:  op = OP_SUBS;
        OPC_B:     op = OP_B;
        OPC_CBZ:   op = OP_CBZ;
        OPC_BCOND: op = OP_BCOND;
        OPC_MOVZ:  op = OP_MOVZ;
        OPC_MOVK:  op = OP_MOVK;
        default:   op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    d       = '0;
    d.valid = 1'b1;
    d.rd    = instruction[4:0];
    d.xfer  = XFER_DWORD;
    d_imm   = '0;
    rn      = 5'd31;
    rm      = 5'd31;
    case (op)
      OP_ADDI:  begin d.ctrl = CTRL_ADDI; d_imm = imm_addi; rn = instruction[9:5]; end
      OP_ADDS:  begin d.ctrl = CTRL_ADDS; d.set_flags = 1'b1; rn = instruction[9:5]; rm = instruction[20:16]; end
      OP_SUBS:  begin d.ctrl = CTRL_SUBS; d.set_flags = 1'b1; rn = instruction[9:5]; rm = instruction[20:16]; end
      OP_STUR:  begin d.ctrl = CTRL_STUR; d_imm = imm_mem; rn = instruction[9:5]; rm = instruction[4:0]; end
      OP_LDUR:  begin d.ctrl = CTRL_LDUR; d_imm = imm_mem; rn = instruction[9:5]; end
      OP_STURB: begin
        d.ctrl = CTRL_STURB; d.xfer = XFER_BYTE; d_imm = imm_mem;
        rn = instruction[9:5]; rm = instruction[4:0];
      end
      OP_LDURB: begin d.ctrl = CTRL_LDURB; d.xfer = XFER_BYTE; d_imm = imm_mem; rn = instruction[9:5]; end
      OP_MOVZ:  begin d.ctrl = CTRL_MOVZ; d_imm = imm_mov; d.shamt = {4'b0000, instruction[22:21]}; end
      OP_MOVK:  begin d.ctrl = CTRL_MOVK; d_imm = imm_mov; d.shamt = {4'b0000, instruction[22:21]}; end
      OP_CBZ:   rm = instruction[4:0];
      OP_B, OP_BCOND: ;
      default:  begin d.illegal = 1'b1; d.rd = 5'd31; end
    endcase
  end

  // A flag-setting op still in EX makes the current NZCV stale for B.cond
  always_comb begin
    flag_stall = (op == OP_BCOND) && ex_valid && ex_set_flags;
    case (op)
      OP_B:     br_taken = 1'b1;
      OP_CBZ:   br_taken = zero_in;
      OP_BCOND: br_taken = !flag_stall && cond_true(instruction[3:0], flags);
      default:  br_taken = 1'b0;
    endcase
    br_offset = (op == OP_B) ? off26 : off19;
  end

  idex_reg #(.XLEN(XLEN)) u_idex_reg (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush_in),
    .stall  (stall_in),
    .bubble (flag_stall),
    .d      (d),
    .d_imm  (d_imm),
    .q      (q),
    .q_imm  (ex_imm)
  );

  assign ex_valid     = q.valid;
  assign ex_illegal   = q.illegal;
  assign ex_set_flags = q.set_flags;
  assign ex_ctrl      = q.ctrl;
  assign ex_rd        = q.rd;
  assign ex_shamt     = q.shamt;
  assign ex_xfer      = q.xfer;

  // Flags follow the EX-stage ALU even while ID/EX is stalled
  always_ff @(posedge clk) begin
    if (reset)                          flags <= 4'b0000;
    else if (ex_valid && ex_set_flags)  flags <= flags_in;
  end

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed-vector bench for pipe_decode_ctrl, with a second instance built
// without byte memory operations.
module tb_pipe_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        stall_in, flush_in, zero_in;
  logic [3:0]  flags_in;

  logic [4:0]  rn, rm, ex_rd;
  logic        br_taken, flag_stall, ex_valid, ex_illegal, ex_set_flags;
  logic [63:0] br_offset, ex_imm;
  logic [12:0] ex_ctrl;
  logic [5:0]  ex_shamt;
  logic [3:0]  ex_xfer, flags;

  logic [4:0]  nb_rn, nb_rm, nb_ex_rd;
  logic        nb_br_taken, nb_flag_stall, nb_ex_valid, nb_ex_illegal, nb_ex_set_flags;
  logic [63:0] nb_br_offset, nb_ex_imm;
  logic [12:0] nb_ex_ctrl;
  logic [5:0]  nb_ex_shamt;
  logic [3:0]  nb_ex_xfer, nb_flags;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [12:0] C_ADDI  = 13'b0000010110000;
  localparam logic [12:0] C_ADDS  = 13'b1000010010000;
  localparam logic [12:0] C_LDUR  = 13'b0011010110010;
  localparam logic [12:0] C_MOVZ  = 13'b0000010111000;
  localparam logic [12:0] C_STURB = 13'b0101010100011;

  localparam logic [31:0] I_ADDI  = 32'h9000_1441; // ADDI X1,X2,#5
  localparam logic [31:0] I_ADDS  = 32'hA805_0083; // ADDS X3,X4,X5
  localparam logic [31:0] I_SUBS  = 32'hE805_0083; // SUBS X3,X4,X5
  localparam logic [31:0] I_BLT   = 32'h5400_008B; // B.LT +4
  localparam logic [31:0] I_BM1   = 32'h17FF_FFFF; // B -1
  localparam logic [31:0] I_CBZ   = 32'hB400_0009; // CBZ X9
  localparam logic [31:0] I_LDUR  = 32'hF85F_80E6; // LDUR X6,[X7,#-8]
  localparam logic [31:0] I_STURB = 32'h3800_0001; // STURB X1,[X0,#0]
  localparam logic [31:0] I_MOVZ  = 32'hD022_4682; // MOVZ X2,#0x1234,LSL 16

  pipe_decode_ctrl #(.XLEN(64), .BYTE_OPS(1)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .stall_in(stall_in),
    .flush_in(flush_in), .zero_in(zero_in), .flags_in(flags_in), .rn(rn), .rm(rm),
    .br_taken(br_taken), .flag_stall(flag_stall), .br_offset(br_offset),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal), .ex_set_flags(ex_set_flags),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_xfer(ex_xfer),
    .ex_imm(ex_imm), .flags(flags)
  );

  pipe_decode_ctrl #(.XLEN(64), .BYTE_OPS(0)) dut_nb (
    .clk(clk), .reset(reset), .instruction(instruction), .stall_in(stall_in),
    .flush_in(flush_in), .zero_in(zero_in), .flags_in(flags_in), .rn(nb_rn), .rm(nb_rm),
    .br_taken(nb_br_taken), .flag_stall(nb_flag_stall), .br_offset(nb_br_offset),
    .ex_valid(nb_ex_valid), .ex_illegal(nb_ex_illegal), .ex_set_flags(nb_ex_set_flags),
    .ex_ctrl(nb_ex_ctrl), .ex_rd(nb_ex_rd), .ex_shamt(nb_ex_shamt), .ex_xfer(nb_ex_xfer),
    .ex_imm(nb_ex_imm), .flags(nb_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instruction = 32'h0; stall_in = 1'b0; flush_in = 1'b0;
    zero_in = 1'b0; flags_in = 4'b0000;
    step(); step();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_imm", ex_imm, 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("nb_rst_all", 64'({nb_ex_valid, nb_ex_illegal, nb_ex_set_flags, nb_ex_ctrl,
                           nb_ex_rd, nb_ex_shamt, nb_ex_xfer, nb_flags}), 64'd0);
    chk("nb_rst_imm", nb_ex_imm, 64'd0);

    // ADDI after reset
    reset = 1'b0; instruction = I_ADDI; #1;
    chk("addi_rn", 64'(rn), 64'd2);
    chk("addi_rm", 64'(rm), 64'd31);
    chk("addi_br", 64'(br_taken), 64'd0);
    step();
    chk("addi_valid", 64'(ex_valid), 64'd1);
    chk("addi_ctrl", 64'(ex_ctrl), 64'(C_ADDI));
    chk("addi_rd", 64'(ex_rd), 64'd1);
    chk("addi_imm", ex_imm, 64'd5);
    chk("addi_setf", 64'(ex_set_flags), 64'd0);
    chk("addi_xfer", 64'(ex_xfer), 64'b1000);

    // SUBS in EX, B.LT in ID: flag hazard stall then resolve
    instruction = I_SUBS; flags_in = 4'b1000;
    step();
    chk("subs_setf", 64'(ex_set_flags), 64'd1);
    instruction = I_BLT; #1;
    chk("haz_stall", 64'(flag_stall), 64'd1);
    chk("haz_br", 64'(br_taken), 64'd0);
    step();
    chk("haz_bubble", 64'(ex_valid), 64'd0);
    chk("haz_bub_ctrl", 64'(ex_ctrl), 64'd0);
    chk("haz_flags", 64'(flags), 64'b1000);
    chk("lt_stall", 64'(flag_stall), 64'd0);
    chk("lt_taken", 64'(br_taken), 64'd1);
    chk("lt_offset", br_offset, 64'd4);

    // Establish flags = 0100 via ADDS
    instruction = I_ADDS; flags_in = 4'b0100; #1;
    chk("adds_rn", 64'(rn), 64'd4);
    chk("adds_rm", 64'(rm), 64'd5);
    step();
    chk("adds_ctrl", 64'(ex_ctrl), 64'(C_ADDS));
    instruction = I_ADDI;
    step();
    chk("flags_0100", 64'(flags), 64'b0100);
    instruction = 32'h5400_0080; #1;
    chk("eq_taken", 64'(br_taken), 64'd1);
    instruction = 32'h5400_0081; #1;
    chk("ne_taken", 64'(br_taken), 64'd0);
    instruction = 32'h5400_008C; #1;
    chk("gt_taken", 64'(br_taken), 64'd0);
    instruction = 32'h5400_008E; #1;
    chk("al_taken", 64'(br_taken), 64'd1);

    // Unconditional and compare-and-branch
    instruction = I_BM1; #1;
    chk("b_taken", 64'(br_taken), 64'd1);
    chk("b_offset", br_offset, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_rnrm", 64'({rn, rm}), 64'({5'd31, 5'd31}));
    chk("nb_b_comb", 64'({nb_br_taken, nb_flag_stall, nb_rn, nb_rm}), 64'({1'b1, 1'b0, 5'd31, 5'd31}));
    chk("nb_b_offset", nb_br_offset, 64'hFFFF_FFFF_FFFF_FFFF);
    instruction = I_CBZ; zero_in = 1'b1; #1;
    chk("cbz_taken", 64'(br_taken), 64'd1);
    chk("cbz_rm", 64'(rm), 64'd9);
    zero_in = 1'b0; #1;
    chk("cbz_not", 64'(br_taken), 64'd0);

    // Memory, byte ops, move-wide, illegal
    instruction = I_LDUR;
    step();
    chk("ldur_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_ctrl", 64'(ex_ctrl), 64'(C_LDUR));
    chk("ldur_rd", 64'(ex_rd), 64'd6);
    instruction = I_STURB;
    step();
    chk("sturb_ctrl", 64'(ex_ctrl), 64'(C_STURB));
    chk("sturb_xfer", 64'(ex_xfer), 64'b0001);
    chk("nb_sturb_ill", 64'(nb_ex_illegal), 64'd1);
    chk("nb_sturb_valid", 64'(nb_ex_valid), 64'd1);
    chk("nb_sturb_ctrl", 64'(nb_ex_ctrl), 64'd0);
    chk("nb_sturb_rd", 64'(nb_ex_rd), 64'd31);
    instruction = I_MOVZ;
    step();
    chk("movz_imm", ex_imm, 64'h1234);
    chk("movz_shamt", 64'(ex_shamt), 64'd1);
    chk("movz_ctrl", 64'(ex_ctrl), 64'(C_MOVZ));
    instruction = 32'h0000_0000;
    step();
    chk("ill_flag", 64'(ex_illegal), 64'd1);
    chk("ill_valid", 64'(ex_valid), 64'd1);
    chk("ill_rd", 64'(ex_rd), 64'd31);

    // Stall with ADDS held in EX
    instruction = I_ADDS; flags_in = 4'b0010;
    step();
    stall_in = 1'b1; instruction = I_SUBS;
    step();
    chk("stall1_ctrl", 64'(ex_ctrl), 64'(C_ADDS));
    chk("stall1_rd", 64'(ex_rd), 64'd3);
    chk("stall1_flags", 64'(flags), 64'b0010);
    step();
    chk("stall2_ctrl", 64'(ex_ctrl), 64'(C_ADDS));
    chk("stall2_valid", 64'(ex_valid), 64'd1);
    chk("stall2_flags", 64'(flags), 64'b0010);

    // Flush beats stall; reset beats a held instruction
    flush_in = 1'b1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_ctrl", 64'(ex_ctrl), 64'd0);
    flush_in = 1'b0; stall_in = 1'b0; instruction = I_ADDI;
    step();
    chk("reload_valid", 64'(ex_valid), 64'd1);
    stall_in = 1'b1;
    step();
    chk("held_rd", 64'(ex_rd), 64'd1);
    reset = 1'b1;
    step();
    chk("rstmid_ex", 64'({ex_valid, ex_illegal, ex_set_flags, ex_ctrl, ex_rd, ex_shamt, ex_xfer}), 64'd0);
    chk("rstmid_imm", ex_imm, 64'd0);
    chk("rstmid_flags", 64'(flags), 64'd0);
    reset = 1'b0; stall_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
